// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage register: valid/ready handshake, optional two-entry
// skid buffer, synchronous flush and a saturating stall-cycle counter.
// All state updates on the falling edge of clk; reset is asynchronous active-low.
module ex_mem_stage #(
    parameter int unsigned N      = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      pc_imm,
    input  logic [N-1:0]      pc_4,
    input  logic [N-1:0]      rs1_data,
    input  logic [N-1:0]      rs2_data,
    input  logic [N-1:0]      alu_result,
    input  logic [REG_W-1:0]  rd,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      pc_imm_o,
    output logic [N-1:0]      pc_4_o,
    output logic [N-1:0]      rs1_data_o,
    output logic [N-1:0]      rs2_data_o,
    output logic [N-1:0]      alu_result_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Payload layout, MSB first: {pc_imm, pc_4, rs1_data, rs2_data, alu_result, rd, ctrl}
    localparam int unsigned PW      = 5 * N + REG_W + CTRL_W;
    localparam int unsigned CTRL_LSB = 0;
    localparam int unsigned RD_LSB   = CTRL_LSB + CTRL_W;
    localparam int unsigned ALU_LSB  = RD_LSB + REG_W;
    localparam int unsigned RS2_LSB  = ALU_LSB + N;
    localparam int unsigned RS1_LSB  = RS2_LSB + N;
    localparam int unsigned PC4_LSB  = RS1_LSB + N;
    localparam int unsigned PCI_LSB  = PC4_LSB + N;

    localparam logic             USE_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       main_q, main_d;
    logic [PW-1:0]       skid_q, skid_d;
    logic                main_valid_q, main_valid_d;
    logic                skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic [PW-1:0]       in_payload_c;
    logic                in_fire_c;
    logic                out_fire_c;

    assign in_payload_c = {pc_imm, pc_4, rs1_data, rs2_data, alu_result, rd, ctrl};

    // With the skid buffer, in_ready is a pure register decode; without it,
    // the single entry may be replaced in the same cycle it is consumed.
    assign in_ready   = USE_SKID ? ~skid_valid_q : (~main_valid_q | out_ready);
    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = main_valid_q & out_ready;

    // Next-state, next-entry and counter logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire_c) begin
                    state_d = ST_ONE;
                    main_d  = in_payload_c;
                end
            end
            ST_ONE: begin
                if (in_fire_c && out_fire_c) begin
                    main_d = in_payload_c;
                end else if (in_fire_c && USE_SKID) begin
                    state_d = ST_FULL;
                    skid_d  = in_payload_c;
                end else if (out_fire_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire_c) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        main_valid_d = (state_d != ST_EMPTY);
        skid_valid_d = (state_d == ST_FULL);
        // Control of a bubble is forced to zero so it can never write a register or memory.
        ctrl_d = main_valid_d ? main_d[CTRL_LSB +: CTRL_W] : '0;

        stall_d = stall_q;
        if (main_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State and storage registers, falling-edge clocked with asynchronous reset.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ctrl_q       <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ctrl_q       <= ctrl_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign pc_imm_o     = main_q[PCI_LSB +: N];
    assign pc_4_o       = main_q[PC4_LSB +: N];
    assign rs1_data_o   = main_q[RS1_LSB +: N];
    assign rs2_data_o   = main_q[RS2_LSB +: N];
    assign alu_result_o = main_q[ALU_LSB +: N];
    assign rd_o         = main_q[RD_LSB +: REG_W];
    assign ctrl_o       = ctrl_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a SKID=1 instance, a SKID=1/CNT_W=4
// instance sharing its stimulus, and a SKID=0 instance with its own handshake.
module tb_ex_mem_stage;

    localparam int unsigned N      = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned PW     = 5 * N + REG_W + CTRL_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid, in_valid0;
    logic              out_ready, out_ready0;
    logic [N-1:0]      pc_imm, pc_4, rs1_data, rs2_data, alu_result;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;

    // SKID=1, CNT_W=16
    logic              in_ready, out_valid;
    logic [N-1:0]      pci_o, pc4_o, rs1_o, rs2_o, alu_o;
    logic [REG_W-1:0]  rd_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [15:0]       stall_cnt;
    // SKID=1, CNT_W=4
    logic              in_ready_s, out_valid_s;
    logic [N-1:0]      pci_s, pc4_s, rs1_s, rs2_s, alu_s;
    logic [REG_W-1:0]  rd_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic [3:0]        stall_cnt_s;
    // SKID=0
    logic              in_ready0, out_valid0;
    logic [N-1:0]      pci_0, pc4_0, rs1_0, rs2_0, alu_0;
    logic [REG_W-1:0]  rd_0;
    logic [CTRL_W-1:0] ctrl_0;
    logic [15:0]       stall_cnt0;

    int n_err    = 0;
    int n_checks = 0;

    logic [PW-1:0] q[$];
    int            stall_m = 0;
    logic          v0      = 1'b0;
    logic [PW-1:0] m0      = '0;
    int            stall0  = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.N(N), .REG_W(REG_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_imm(pc_imm), .pc_4(pc_4), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_result(alu_result), .rd(rd), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_imm_o(pci_o), .pc_4_o(pc4_o), .rs1_data_o(rs1_o), .rs2_data_o(rs2_o),
        .alu_result_o(alu_o), .rd_o(rd_o), .ctrl_o(ctrl_o), .stall_cnt(stall_cnt)
    );

    ex_mem_stage #(.N(N), .REG_W(REG_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .pc_imm(pc_imm), .pc_4(pc_4), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_result(alu_result), .rd(rd), .ctrl(ctrl),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .pc_imm_o(pci_s), .pc_4_o(pc4_s), .rs1_data_o(rs1_s), .rs2_data_o(rs2_s),
        .alu_result_o(alu_s), .rd_o(rd_s), .ctrl_o(ctrl_s), .stall_cnt(stall_cnt_s)
    );

    ex_mem_stage #(.N(N), .REG_W(REG_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
        .pc_imm(pc_imm), .pc_4(pc_4), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_result(alu_result), .rd(rd), .ctrl(ctrl),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .pc_imm_o(pci_0), .pc_4_o(pc4_0), .rs1_data_o(rs1_0), .rs2_data_o(rs2_0),
        .alu_result_o(alu_0), .rd_o(rd_0), .ctrl_o(ctrl_0), .stall_cnt(stall_cnt0)
    );

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full payload derived from the alu_result value so every field is distinct.
    function automatic logic [PW-1:0] mk(input logic [N-1:0] a, input logic [CTRL_W-1:0] c);
        logic [REG_W-1:0] r;
        r = a[REG_W-1:0] + REG_W'(1);
        return {a ^ 32'hA5A5_0000, a + 32'd4, a ^ 32'h0000_FFFF, ~a, a, r, c};
    endfunction

    task automatic drive(input logic [PW-1:0] p);
        {pc_imm, pc_4, rs1_data, rs2_data, alu_result, rd, ctrl} = p;
    endtask

    task automatic check_main();
        logic [PW-1:0] obs, obs_s;
        int exp_sat;
        obs   = {pci_o, pc4_o, rs1_o, rs2_o, alu_o, rd_o, ctrl_o};
        obs_s = {pci_s, pc4_s, rs1_s, rs2_s, alu_s, rd_s, ctrl_s};
        exp_sat = (stall_m > 15) ? 15 : stall_m;
        check("out_valid", PW'(out_valid), PW'(q.size() > 0));
        check("out_valid_sat", PW'(out_valid_s), PW'(q.size() > 0));
        if (q.size() > 0) begin
            check("payload", obs, q[0]);
            check("payload_sat", obs_s, q[0]);
        end else begin
            check("bubble_ctrl", PW'(ctrl_o), PW'(0));
        end
        check("stall_cnt", PW'(stall_cnt), PW'(stall_m));
        check("stall_cnt_sat", PW'(stall_cnt_s), PW'(exp_sat));
    endtask

    // One clock of stimulus to the SKID=1 instances; scoreboard updated at the falling edge.
    task automatic cycle(input logic iv, input logic [PW-1:0] p, input logic ordy, input logic fl);
        logic in_fire, out_fire;
        @(posedge clk);
        in_valid  = iv;
        drive(p);
        out_ready = ordy;
        flush     = fl;
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        #1;
        check("in_ready", PW'(in_ready), PW'(q.size() < 2));
        check("in_ready_sat", PW'(in_ready_s), PW'(q.size() < 2));
        in_fire  = iv && (q.size() < 2);
        out_fire = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy) stall_m++;
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(p);
        end
        @(negedge clk);
        #1;
        check_main();
    endtask

    // One clock of stimulus to the SKID=0 instance; the others stay idle and empty.
    task automatic cycle0(input logic iv, input logic [PW-1:0] p, input logic ordy);
        logic in_fire, out_fire;
        logic [PW-1:0] obs;
        @(posedge clk);
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        flush      = 1'b0;
        drive(p);
        in_valid0  = iv;
        out_ready0 = ordy;
        #1;
        check("in_ready0", PW'(in_ready0), PW'(!v0 || ordy));
        in_fire  = iv && (!v0 || ordy);
        out_fire = v0 && ordy;
        if (v0 && !ordy) stall0++;
        if (in_fire) begin
            v0 = 1'b1;
            m0 = p;
        end else if (out_fire) begin
            v0 = 1'b0;
        end
        @(negedge clk);
        #1;
        obs = {pci_0, pc4_0, rs1_0, rs2_0, alu_0, rd_0, ctrl_0};
        check("out_valid0", PW'(out_valid0), PW'(v0));
        if (v0) check("payload0", obs, m0);
        else    check("bubble_ctrl0", PW'(ctrl_0), PW'(0));
        check("stall_cnt0", PW'(stall_cnt0), PW'(stall0));
    endtask

    // Reset asserted between edges: outputs must clear immediately.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_payload", {pci_o, pc4_o, rs1_o, rs2_o, alu_o, rd_o, ctrl_o}, PW'(0));
        check("rst_stall_cnt", PW'(stall_cnt), PW'(0));
        check("rst_in_ready", PW'(in_ready), PW'(1));
        check("rst_out_valid0", PW'(out_valid0), PW'(0));
        q.delete();
        stall_m = 0;
        v0      = 1'b0;
        stall0  = 0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [PW-1:0] idle;
        idle       = '0;
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_valid0  = 1'b0;
        out_ready  = 1'b1;
        out_ready0 = 1'b1;
        drive(idle);
        #3;
        check("init_out_valid", PW'(out_valid), PW'(0));
        check("init_payload", {pci_o, pc4_o, rs1_o, rs2_o, alu_o, rd_o, ctrl_o}, PW'(0));
        check("init_in_ready", PW'(in_ready), PW'(1));
        reset = 1'b1;

        // First transaction after reset
        cycle(1'b1, mk(32'h0000_1234, 7'b1000001), 1'b1, 1'b0);
        check("first_alu", PW'(alu_o), PW'(32'h0000_1234));
        check("first_ctrl", PW'(ctrl_o), PW'(7'b1000001));
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Back-to-back streaming
        for (int i = 1; i <= 8; i++) cycle(1'b1, mk(32'(i), 7'(i)), 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        check("stream_stall", PW'(stall_cnt), PW'(0));

        // Back-pressure: A then B fill main and skid, then drain
        cycle(1'b1, mk(32'hAAAA_0001, 7'b1100000), 1'b0, 1'b0);
        cycle(1'b1, mk(32'hBBBB_0002, 7'b0000110), 1'b0, 1'b0);
        cycle(1'b1, mk(32'hCCCC_0003, 7'b1000001), 1'b0, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Flush while FULL, with a same-edge entry that must be discarded
        cycle(1'b1, mk(32'h0000_00A2, 7'b1000000), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h0000_00B2, 7'b0000010), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h0000_00C2, 7'b1111111), 1'b0, 1'b1);
        cycle(1'b0, idle, 1'b1, 1'b0);
        // Flush while ONE with an entry that would otherwise be accepted
        cycle(1'b1, mk(32'h0000_00A3, 7'b0100000), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h0000_00D3, 7'b1111111), 1'b1, 1'b1);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Hold a stalled entry for 20 edges to saturate the 4-bit counter
        cycle(1'b1, mk(32'h0000_00E4, 7'b0001000), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, idle, 1'b0, 1'b0);
        check("sat_value", PW'(stall_cnt_s), PW'(15));
        cycle(1'b0, idle, 1'b1, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), mk(32'($urandom), 7'($urandom)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b1, 1'b0);

        // Reset mid-operation, then a fresh transaction
        cycle(1'b1, mk(32'h0000_00F5, 7'b1000001), 1'b0, 1'b0);
        mid_reset();
        cycle(1'b1, mk(32'h0000_1234, 7'b1000001), 1'b1, 1'b0);
        cycle(1'b0, idle, 1'b1, 1'b0);

        // SKID=0: combinational in_ready and same-cycle replacement
        cycle0(1'b1, mk(32'h0000_0101, 7'b1000000), 1'b0);
        cycle0(1'b1, mk(32'h0000_0202, 7'b0100000), 1'b0);
        cycle0(1'b1, mk(32'h0000_0303, 7'b0000001), 1'b1);
        check("skid0_replace", PW'(alu_0), PW'(32'h0000_0303));
        cycle0(1'b1, mk(32'h0000_0404, 7'b0010000), 1'b1);
        cycle0(1'b0, idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global time bound so a stuck run still ends with a failure line.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline stage register with a valid/ready handshake, an optional skid buffer, synchronous flush and a stall-cycle counter. It sits between the execute stage and the memory stage of the RISC-V datapath. It carries the branch target, link address, operand values, ALU result, destination register and the control bundle. Stalls back-pressure cleanly, and flushes insert bubbles whose control bits are all zero.

## Interface
- N, 32, datapath width of the pc_imm, pc_4, rs1_data, rs2_data and alu_result fields
- REG_W, 5, destination register index width
- CTRL_W, 7, control bundle width; bit order {reg_write, branch, jal, jalr, mem_read, mem_write, mem_to_reg}, MSB first
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  stage clock; all state updates on the falling edge
- reset  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage accepts this cycle
- pc_imm, pc_4, rs1_data, rs2_data, alu_result  in  N each  EX payload
- rd  in  REG_W  destination register
- ctrl  in  CTRL_W  control bundle
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes this cycle
- pc_imm_o, pc_4_o, rs1_data_o, rs2_data_o, alu_result_o  out  N each  held payload
- rd_o  out  REG_W  held destination register
- ctrl_o  out  CTRL_W  held control; forced to 0 whenever out_valid=0
- stall_cnt  out  CNT_W  saturating count of stall edges

## Operation
- Handshake terms:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Payload is packed as {pc_imm, pc_4, rs1_data, rs2_data, alu_result, rd, ctrl}.
- Storage:
  - main entry drives the outputs; main_valid = out_valid
  - skid entry exists only when SKID=1
- States and next-state rules (SKID=1):
  - EMPTY: in_fire -> ONE, main <= in
  - ONE, in_fire & out_fire -> ONE, main <= in
  - ONE, in_fire & !out_fire -> FULL, skid <= in
  - ONE, !in_fire & out_fire -> EMPTY
  - ONE, otherwise -> hold
  - FULL: out_fire -> ONE, main <= skid, skid cleared; otherwise hold. in_fire is impossible in FULL.
- in_ready:
  - SKID=1: in_ready = !skid_valid (a register, no input-to-output path)
  - SKID=0: in_ready = !out_valid | out_ready; FULL is unreachable
- ctrl_o = main ctrl & {CTRL_W{out_valid}}, so no bubble can assert reg_write or mem_write.
- Data fields of an invalid entry hold their last value; their contents are don't-care.
- flush = 1 at an edge:
  - next state EMPTY, main_valid = skid_valid = 0
  - any same-edge in_fire is discarded
  - flush has priority over every other transition
- stall_cnt increments at every edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W - 1.
  - Cleared only by reset.
  - Not affected by flush.

## Timing
- Reset (asserted low, asynchronous), every output and state bit:
  - out_valid = 0, ctrl_o = 0, rd_o = 0, stall_cnt = 0
  - all N-wide outputs = 0
  - skid_valid = 0, so in_ready = 1 during and after reset
- Reset deasserted mid-operation: the stage restarts in EMPTY; any in-flight entries are lost.
- Latency is 1 falling edge from in_fire to the payload at the outputs with out_valid = 1.
- Throughput is 1 entry per cycle when out_ready = 1 continuously.
- SKID=1 with out_ready low:
  - first accepted entry sits in main, second in skid
  - in_ready falls at the edge that fills skid
  - in_ready rises at the edge where skid moves to main
- Ordering is strict FIFO. An entry is never duplicated or dropped except by flush or reset.
- Outputs are stable between edges. out_valid changes only at edges or on reset assertion.

## Test plan
- Reset checks:
  - Assert reset low mid-cycle -> all outputs 0 immediately, in_ready = 1.
  - Release reset, then in_valid = 1 with alu_result = 0x0000_1234 and ctrl = 7'b1000001 -> next falling edge: out_valid = 1, alu_result_o = 0x0000_1234, ctrl_o = 7'b1000001.
- Streaming: 8 back-to-back entries (alu_result = 1..8) with out_ready = 1 -> outputs show 1..8 on consecutive edges, stall_cnt = 0.
- Back-pressure, SKID=1:
  - Send A and B with out_ready = 0 -> in_ready = 0 after B is captured; A stays on the outputs.
  - Raise out_ready for 2 cycles -> A then B are delivered, in_ready = 1 again, stall_cnt = number of stalled edges.
- Flush while FULL: assert flush with in_valid = 1 (entry C) -> next edge out_valid = 0, ctrl_o = 0, C is never output.
- Counter saturation: with CNT_W = 4, hold out_valid = 1 and out_ready = 0 for 20 edges -> stall_cnt = 15 and stays at 15.
- SKID=0 build: out_valid = 1, out_ready = 1, in_valid = 1 -> in_ready = 1 in the same cycle and the entry is replaced without a bubble.
